// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-side arbiter: FSM encoding and
// default parameter values.
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    STALL = 2'd2
  } state_t;

  localparam int NUM_REQ_DEF    = 4;
  localparam int DATA_WIDTH_DEF = 4;
  localparam int BURST_LEN_DEF  = 4;
  localparam int ERR_CNT_W      = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set request at or
// after ptr (wrapping), as a one-hot vector and as an index.
module rr_pick #(
  parameter int n  = 4,
  parameter int pw = 2
) (
  input  logic [n-1:0]  req,
  input  logic [pw-1:0] ptr,
  output logic [n-1:0]  pick,
  output logic [pw-1:0] idx,
  output logic          any
);

  // Scan from ptr upward and keep the first hit.
  always_comb begin
    int k;
    k    = 0;
    pick = '0;
    idx  = '0;
    any  = 1'b0;
    for (int off = 0; off < n; off++) begin
      k = int'(ptr) + off;
      if (k >= n) k = k - n;
      if (!any && req[k]) begin
        pick[k] = 1'b1;
        idx     = pw'(k);
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that lets several producers share one FIFO write port.
// Each grant lasts up to burst_len beats; beats are acked combinationally and
// written to the FIFO one cycle later. Full / almost-full stall the grant.
//
// Handshake: a producer holds req_in[i] high with its word on data_in; a beat
// is accepted in any cycle where ack_out[i]=1, and the producer may present
// its next word in the following cycle. wt_en_out/data_out carry the accepted
// word in the cycle after the accept.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int num_req    = NUM_REQ_DEF,
  parameter int data_width = DATA_WIDTH_DEF,
  parameter int burst_len  = BURST_LEN_DEF
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [num_req-1:0]            req_in,
  input  logic [num_req*data_width-1:0] data_in,
  input  logic                          full_in,
  input  logic                          almost_full_in,
  input  logic                          push_on_full_error_in,
  output logic [num_req-1:0]            grant_out,
  output logic [num_req-1:0]            ack_out,
  output logic                          wt_en_out,
  output logic [data_width-1:0]         data_out,
  output logic                          busy_out,
  output logic [ERR_CNT_W-1:0]          err_cnt_out,
  output state_t                        state_out
);

  localparam int         PW        = (num_req > 1) ? $clog2(num_req) : 1;
  localparam logic [3:0] LAST_BEAT = 4'(burst_len - 1);

  state_t          state_q;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   next_ptr;
  logic [PW-1:0]   pick_idx;
  logic [num_req-1:0] pick_oh;
  logic            pick_any;
  logic [3:0]      beat_cnt;
  logic            owner_req;
  logic            space;
  logic            accept;

  rr_pick #(.n(num_req), .pw(PW)) u_pick (
    .req  (req_in),
    .ptr  (rr_ptr),
    .pick (pick_oh),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // A write issued last cycle consumes the last slot when almost full.
  assign space     = !full_in && !(almost_full_in && wt_en_out);
  assign owner_req = req_in[owner];
  assign accept    = (state_q == GRANT) && owner_req && space && !rst_in;
  assign ack_out   = accept ? grant_out : '0;
  assign next_ptr  = (owner == PW'(num_req - 1)) ? '0 : owner + 1'b1;
  assign busy_out  = (state_q != IDLE);
  assign state_out = state_q;

  // Arbitration FSM with registered grant and FIFO write outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      beat_cnt  <= '0;
      grant_out <= '0;
      wt_en_out <= 1'b0;
      data_out  <= '0;
    end else begin
      wt_en_out <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            grant_out <= pick_oh;
            owner     <= pick_idx;
            beat_cnt  <= '0;
            state_q   <= GRANT;
          end
        end
        GRANT: begin
          if (!owner_req) begin
            grant_out <= '0;
            rr_ptr    <= next_ptr;
            state_q   <= IDLE;
          end else if (space) begin
            wt_en_out <= 1'b1;
            data_out  <= data_in[int'(owner)*data_width +: data_width];
            beat_cnt  <= beat_cnt + 4'd1;
            if (beat_cnt == LAST_BEAT) begin
              grant_out <= '0;
              rr_ptr    <= next_ptr;
              state_q   <= IDLE;
            end
          end else begin
            state_q <= STALL;
          end
        end
        STALL: begin
          if (!owner_req) begin
            grant_out <= '0;
            rr_ptr    <= next_ptr;
            state_q   <= IDLE;
          end else if (space) begin
            state_q <= GRANT;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Saturating count of push-on-full errors reported by the FIFO.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      err_cnt_out <= '0;
    end else if (push_on_full_error_in && (err_cnt_out != '1)) begin
      err_cnt_out <= err_cnt_out + 1'b1;
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter: num_req, 4, number of producer ports (2..8).
REQ-002 Parameter: data_width, 4, FIFO data word width.
REQ-003 Parameter: burst_len, 4, maximum beats per grant before rotation (1..15).
REQ-004 clk_in  input  1  sole clock: the FIFO write-side clock.
REQ-005 rst_in  input  1  synchronous, active-high reset.
REQ-006 req_in  input  num_req  per-producer write request, level, held until acked.
REQ-007 data_in  input  num_req*data_width  producer words; producer i occupies bits [i*data_width +: data_width].
REQ-008 full_in  input  1  FIFO full status.
REQ-009 almost_full_in  input  1  FIFO has at most one free slot.
REQ-010 push_on_full_error_in  input  1  FIFO push-on-full error pulse.
REQ-011 grant_out  output  num_req  one-hot current owner, or zero.
REQ-012 ack_out  output  num_req  one-hot, one cycle per accepted beat; the producer presents its next word in the following cycle.
REQ-013 wt_en_out  output  1  registered FIFO write enable.
REQ-014 data_out  output  data_width  registered FIFO write data.
REQ-015 busy_out  output  1  high in GRANT or STALL.
REQ-016 err_cnt_out  output  8  saturating count of push-on-full errors.

Function
REQ-017 FSM states: IDLE, GRANT, STALL.
REQ-018 IDLE: if any req_in bit is set, select the first requester at or after rr_ptr (wrapping), load grant_out, clear beat_cnt, and enter GRANT next cycle. Otherwise remain in IDLE with grant_out=0.
REQ-019 Space condition: space = !full_in && !(almost_full_in && wt_en_out).
REQ-020 GRANT, owner g: if req_in[g] && space, then ack_out[g]=1 combinationally, and in the next cycle wt_en_out=1 and data_out=word g from the accept cycle. beat_cnt increments.
REQ-021 GRANT with req_in[g] && !space: no ack; go to STALL.
REQ-022 STALL: hold grant_out. Return to GRANT when space=1; no ack is issued in the transition cycle. Go to IDLE if req_in[g] drops.
REQ-023 Grant ends in either case: the beat_cnt=burst_len beat is acked, or req_in[g]=0 in GRANT. Next state is IDLE, grant_out clears, and rr_ptr=(g+1) mod num_req.
REQ-024 Accept-to-write latency is exactly 1 cycle. Sustained throughput is one beat per cycle within a grant, plus one IDLE cycle per rotation.
REQ-025 wt_en_out=0 in every cycle not following an accept. data_out holds its last value when idle.
REQ-026 ack_out is never asserted for a non-owner. At most one ack_out bit is set at a time.
REQ-027 err_cnt_out increments on each cycle push_on_full_error_in=1 and saturates at 255.
REQ-028 Requests arriving mid-grant wait. A requester dropping req while not granted loses nothing.

Reset
REQ-029 When rst_in=1 at a clk_in edge: state=IDLE, rr_ptr=0, beat_cnt=0, grant_out=0, wt_en_out=0, data_out=0, err_cnt_out=0. ack_out=0 while rst_in=1.
REQ-030 Reset mid-burst abandons the burst and issues no write in the following cycle.

Structure
REQ-031 Shared package fifo_pkg holds the FSM state encoding and default parameter constants.
REQ-032 One sub-module, rr_pick: combinational round-robin one-hot picker taking req and rr_ptr.
REQ-033 Target size is 120-400 RTL lines. No clock-domain crossing inside this block.

Verification
REQ-034 Reset release, req_in=4'b0000 -> grant_out=0, wt_en_out=0, busy_out=0, err_cnt_out=0.
REQ-035 req_in=4'b0101 held, full_in=0, burst_len=4 -> port0 receives 4 acks (data 1,2,3,4 written one cycle later), then 1 IDLE cycle, then port2 receives 4 acks.
REQ-036 Port1 granted, full_in rises after beat 2 -> STALL with no ack and wt_en_out=0. When full_in falls -> beat 3 acks one cycle later.
REQ-037 almost_full_in=1 while wt_en_out=1 -> no ack that cycle. No FIFO overflow occurs.
REQ-038 All four requesting continuously for 16 grants -> grant order 0,1,2,3,0,1,2,3,... with equal beat counts.
REQ-039 300 push_on_full_error_in pulses -> err_cnt_out=255. rst_in mid-burst -> next-cycle wt_en_out=0 and state=IDLE.
